muldiv_sequencer: RTL and testbench

//  Multi-cycle controller and datapath for MULT/MULTU/DIV/DIVU and the HI/LO register pair.
//  - Sits beside the EX stage and runs a radix-2 shift-add multiply or restoring divide, one bit per cycle.
//  - Holds the pipeline with a stall while a new mul/div op or an MFHI/MFLO read hits a busy unit.
//  - Owns HI/LO; MFHI/MFLO read them through hi/lo.

---
 rtl/muldiv_sequencer_if.sv | 26 ++
 rtl/muldiv_sequencer.sv | 146 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the mul/div sequencer.
interface muldiv_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              op_valid;
  logic [1:0]        op_code;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              rd_req;
  logic              stall;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output op_valid, op_code, op_a, op_b, rd_req,
    input  stall, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, rd_req,
    output stall, busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer (radix-2 shift-add / restoring divide) owning HI/LO.
// Optional build macro MULDIV_EARLY_OUT_EN: early multiply finish and immediate divide-by-zero.
module muldiv_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                busy_r;
  logic                done_r;
  logic                dz_r;
  logic [DATA_W-1:0]   hi_r;
  logic [DATA_W-1:0]   lo_r;

  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   mplier;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   raw_a;
  logic                neg_lo;
  logic                neg_hi;
  logic                is_div;
  logic                by_zero;

  logic                op_signed;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W:0]     trial;
  logic                last_iter;
  logic                mul_exhausted;
  logic [2*DATA_W-1:0] prod_fix;

  function automatic logic [DATA_W-1:0] cond_neg_w(input logic signed [DATA_W-1:0] v,
                                                  input logic neg);
    return neg ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg_2w(input logic [2*DATA_W-1:0] v,
                                                     input logic neg);
    return neg ? -v : v;
  endfunction

  assign op_signed = ~bus.op_code[0];
  assign a_neg     = op_signed & bus.op_a[DATA_W-1];
  assign b_neg     = op_signed & bus.op_b[DATA_W-1];
  // Partial remainder with the next dividend bit shifted in, minus divisor; MSB set means restore.
  assign trial     = {rem, quo[DATA_W-1]} - {1'b0, mplier};
  assign last_iter = (cnt == CNT_W'(DATA_W - 1));
  assign prod_fix  = cond_neg_2w(prod, neg_lo);

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_exhausted = (mplier[DATA_W-1:1] == '0);
`else
  assign mul_exhausted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            mcand   <= {{DATA_W{1'b0}}, cond_neg_w(bus.op_a, a_neg)};
            prod    <= '0;
            mplier  <= cond_neg_w(bus.op_b, b_neg);
            quo     <= cond_neg_w(bus.op_a, a_neg);
            rem     <= '0;
            raw_a   <= bus.op_a;
            is_div  <= bus.op_code[1];
            by_zero <= (bus.op_b == '0);
            neg_lo  <= a_neg ^ b_neg;
            neg_hi  <= bus.op_code[1] ? a_neg : (a_neg ^ b_neg);
            cnt     <= '0;
            busy_r  <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            if (bus.op_code[1] && (bus.op_b == '0)) state <= FIX;
            else                                   state <= bus.op_code[1] ? DIV : MUL;
`else
            state   <= bus.op_code[1] ? DIV : MUL;
`endif
          end
        end
        MUL: begin
          prod   <= prod + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter || mul_exhausted) state <= FIX;
        end
        DIV: begin
          if (!trial[DATA_W]) begin
            rem <= trial[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], 1'b1};
          end else begin
            rem <= {rem[DATA_W-2:0], quo[DATA_W-1]};
            quo <= {quo[DATA_W-2:0], 1'b0};
          end
          cnt <= cnt + CNT_W'(1);
          if (last_iter) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            if (by_zero) begin
              lo_r <= '1;
              hi_r <= raw_a;
            end else begin
              lo_r <= cond_neg_w(quo, neg_lo);
              hi_r <= cond_neg_w(rem, neg_hi);
            end
          end else begin
            hi_r <= prod_fix[2*DATA_W-1:DATA_W];
            lo_r <= prod_fix[DATA_W-1:0];
          end
          done_r <= 1'b1;
          dz_r   <= is_div & by_zero;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall    = busy_r & (bus.op_valid | bus.rd_req);
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer with an arithmetic reference model and per-cycle compare.
`timescale 1ns/1ps
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.DATA_W(W)) bus ();
  muldiv_sequencer #(.DATA_W(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  int         m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic       m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Result as {div_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [2*W:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      2'b00: begin q = sa * sb; return {1'b0, q}; end
      2'b01: begin uq = ua * ub; return {1'b0, uq}; end
      2'b10: begin
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[W-1:0], q[W-1:0]};
      end
      default: begin
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        uq = ua / ub;
        ur = ua % ub;
        return {1'b0, ur[W-1:0], uq[W-1:0]};
      end
    endcase
  endfunction

  // Number of cycles busy is high for an accepted op.
  function automatic int ref_busy(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [W-1:0] m;
    int n;
    if (op[1]) return (b == '0) ? 1 : W + 1;
    m = (op[0] == 1'b0 && b[W-1]) ? -b : b;
    n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return n + 1;
`else
    return W + 1;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_left == 0) begin
        if (bus.op_valid) begin
          {p_dz, p_hi, p_lo} <= ref_result(bus.op_code, bus.op_a, bus.op_b);
          m_left <= ref_busy(bus.op_code, bus.op_a, bus.op_b);
        end
      end else if (m_left == 1) begin
        m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1; m_dz <= p_dz; m_left <= 0;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", bus.busy, m_left != 0);
      check("stall", bus.stall, (m_left != 0) && (bus.op_valid || bus.rd_req));
      check("done", bus.done, m_done);
      check("div_zero", bus.div_zero, m_dz);
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm, output int k, output bit got);
    got = 1'b0;
    k = 1;
    while (k < 200 && !got) begin
      if (bus.done) got = 1'b1;
      else begin tick(); k++; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got no done, required done within 200 cycles", nm);
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edz);
    int k;
    bit got;
    bus.op_valid = 1'b1; bus.op_code = op; bus.op_a = a; bus.op_b = b;
    tick();
    bus.op_valid = 1'b0;
    wait_done(nm, k, got);
    if (got) begin
      check({nm, "_lat"}, k, ref_busy(op, a, b) + 1);
      check({nm, "_hi"}, bus.hi, ehi);
      check({nm, "_lo"}, bus.lo, elo);
      check({nm, "_dz"}, bus.div_zero, edz);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return W'($urandom % 16);
      4: return -W'($urandom % 16);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int k;
    bit got;
    int dones;
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op_code = 2'b00; bus.op_a = '0; bus.op_b = '0; bus.rd_req = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk_on = 1'b1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);

    run_op("mult_neg", 2'b00, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div_neg", 2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    run_op("div_minint", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("div_zero_s", 2'b10, -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    run_op("div_rem_sign", 2'b10, 32'd7, -32'sd2, 32'h1, 32'hFFFF_FFFD, 1'b0);
    run_op("multu_9x1", 2'b01, 32'd9, 32'd1, 32'h0, 32'd9, 1'b0);
`ifdef MULDIV_EARLY_OUT_EN
    run_op("early_mul", 2'b01, 32'd9, 32'd1, 32'h0, 32'd9, 1'b0);
`endif

    // Read request arriving while a multiply is in flight
    bus.op_valid = 1'b1; bus.op_code = 2'b00; bus.op_a = 32'd6; bus.op_b = 32'd7;
    tick();
    bus.op_valid = 1'b0;
    tick(); tick();
    bus.rd_req = 1'b1;
    wait_done("rd_stall", k, got);
    if (got) begin
      check("rd_stall_on_done", bus.stall, 1'b0);
      check("rd_new_lo", bus.lo, 32'd42);
    end
    tick();
    bus.rd_req = 1'b0;

    // Second op held while busy, accepted on the done cycle
    bus.op_valid = 1'b1; bus.op_code = 2'b01; bus.op_a = 32'd100; bus.op_b = 32'd3;
    tick();
    bus.op_code = 2'b11; bus.op_a = 32'd100; bus.op_b = 32'd7;
    check("b2b_stall", bus.stall, 1'b1);
    wait_done("b2b_first", k, got);
    if (got) begin
      check("b2b_first_lo", bus.lo, 32'd300);
      check("b2b_accept_nostall", bus.stall, 1'b0);
    end
    tick();
    bus.op_valid = 1'b0;
    wait_done("b2b_second", k, got);
    if (got) begin
      check("b2b_second_lo", bus.lo, 32'd14);
      check("b2b_second_hi", bus.hi, 32'd2);
    end
    tick();

    // Reset in the middle of a divide
    bus.op_valid = 1'b1; bus.op_code = 2'b10; bus.op_a = 32'd1000; bus.op_b = 32'd3;
    tick();
    bus.op_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    dones = 0;
    for (int i = 0; i < W + 6; i++) begin
      if (bus.done) dones++;
      tick();
    end
    check("abort_no_done", dones, 0);

    // Random traffic, including ops presented while busy and rare resets
    for (int i = 0; i < 3000; i++) begin
      bus.op_valid = ($urandom % 3) == 0;
      bus.op_code  = 2'($urandom);
      bus.op_a     = pick();
      bus.op_b     = pick();
      bus.rd_req   = ($urandom % 4) == 0;
      rst          = ($urandom % 700) == 0;
      tick();
    end
    rst = 1'b0; bus.op_valid = 1'b0; bus.rd_req = 1'b0;
    repeat (W + 4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
